// File: rtl/adpcm_b_requester_if.sv
// Host-side request/response bundle for adpcm_b_requester.
// The master issues fetch requests; the slave answers with a one-cycle response pulse.
interface adpcm_b_requester_if;
  logic        req_valid;
  logic [23:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/adpcm_b_requester.sv
// YM2610-side ADPCM-B sample-bus requester: drives PMPX and the multiplexed address.
// Define ADPCM_B_REQUESTER_STATS_EN to add saturating ok/timeout counters.
module adpcm_b_requester #(
  parameter int PMPX_HIGH_CYCLES = 6,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                clk,
  input  logic                reset,
  adpcm_b_requester_if.slave  host,
  output logic                pmpx,
  output logic [3:0]          ym_io_in,
  input  logic [2:0]          mux_sel,
  input  logic                mux_oe_n,
  input  logic [3:0]          ym_io_out,
  input  logic                ym_io_en,
  input  logic                pcm_load
`ifdef ADPCM_B_REQUESTER_STATS_EN
  ,
  input  logic                stat_clear,
  output logic [15:0]         stat_ok,
  output logic [15:0]         stat_timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR_LO,
    ADDR_HI
  } state_t;

  localparam logic [15:0] P_LAST = 16'(PMPX_HIGH_CYCLES - 1);
  localparam logic [15:0] T_LIM  = 16'(TIMEOUT_CYCLES);

  state_t      state, state_nx;
  logic [23:0] addr;
  logic [15:0] cnt;
  logic [3:0]  hi, lo;
  logic        done;
  logic [7:0]  data_q;
  logic [11:0] bus12;
  logic        accept, lo_cap, hi_cap, tmo, fin;

  assign accept = (state == IDLE) && host.req_valid;
  assign lo_cap = (state == ADDR_HI) && ym_io_en &&
                  (mux_sel == 3'b101);
  assign hi_cap = (state == ADDR_HI) && ym_io_en &&
                  pcm_load && !done;
  // A completed capture wins over a timeout in the same cycle.
  assign fin    = (state == ADDR_HI) && done;
  assign tmo    = (state == ADDR_HI) && !done &&
                  (cnt == T_LIM);

  assign host.req_ready  = (state == IDLE);
  assign host.resp_valid = fin || tmo;
  assign host.resp_err   = tmo;
  assign host.resp_data  = fin ? {hi, lo} :
                           tmo ? 8'h00 : data_q;
  assign pmpx  = (state == ADDR_LO);
  assign bus12 = (state == ADDR_HI) ? addr[23:12] : addr[11:0];

  always_comb begin
    ym_io_in = 4'h0;
    if (!mux_oe_n) begin
      unique case (1'b1)
        (mux_sel == 3'b010): ym_io_in = bus12[3:0];
        (mux_sel == 3'b110): ym_io_in = bus12[7:4];
        (mux_sel == 3'b011): ym_io_in = bus12[11:8];
        default:             ym_io_in = 4'h0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ADDR_LO;
      ADDR_LO: if (cnt == P_LAST) state_nx = ADDR_HI;
      ADDR_HI: if (fin || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cnt counts from the PMPX rise; it times both phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr <= host.req_addr;
        cnt  <= '0;
        hi   <= '0;
        lo   <= '0;
        done <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= cnt + 16'd1;
      end
      if (lo_cap) lo <= ym_io_out;
      if (hi_cap) begin
        hi   <= ym_io_out;
        done <= 1'b1;
      end
      if (host.resp_valid) data_q <= host.resp_data;
    end
  end

`ifdef ADPCM_B_REQUESTER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_ok      <= '0;
      stat_timeout <= '0;
    end else begin
      if (fin && stat_ok != 16'hFFFF)
        stat_ok <= stat_ok + 16'd1;
      if (tmo && stat_timeout != 16'hFFFF)
        stat_timeout <= stat_timeout + 16'd1;
    end
  end
`endif

endmodule
